// File: rtl/uart_rx_8n1_pkg.sv
// Shared definitions for the 8N1 UART blocks: FSM encodings, default bit
// timing for a 12 MHz hwclk at 9600 baud, and the fixed 8N1 frame shape.
package uart_rx_8n1_pkg;

  // Receiver FSM states, explicit 3-bit encodings.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_t;

  // 12_000_000 / 9600 = 1250 hwclk cycles per bit.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 1250;

  // 8N1 frame: one start bit, eight data bits LSB first, no parity, one stop bit.
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/uart_rx_8n1_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is
// a parameter so idle-high lines (UART rx, keypad columns) come out of reset
// without a false edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops to resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver. Detects the start edge on the synchronized line,
// re-centres on the start bit after half a bit time, then samples eight data
// bits and the stop bit one full bit time apart. Good bytes are delivered
// with a valid/ack handshake; a low stop bit pulses frame_err and the FSM
// waits for the line to return high before hunting for a new start bit.
module uart_rx_8n1
  import uart_rx_8n1_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT  // even, >= 8
) (
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rxbyte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             rx_s;

  logic half_done, bit_done;
  logic cnt_clr, cnt_inc, idx_clr, shift_en, deliver, bad_stop;
  logic overrun_event;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (hwclk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  assign half_done = (cnt_q == HALF_LAST);
  assign bit_done  = (cnt_q == BIT_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: frame sequencing on rx_s and the counter terminals.
  // NOTE: the default assignment on entry keeps every path assigned, so no
  // latch is inferred for state_d.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!rx_s) state_d = ST_START;
      ST_START:     if (half_done) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (bit_done && (bit_idx_q == IDX_LAST)) state_d = ST_STOP;
      ST_STOP:      if (bit_done) state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rx_s) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output/control decode: counter control, data sampling and stop-bit verdict.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    idx_clr  = 1'b0;
    shift_en = 1'b0;
    deliver  = 1'b0;
    bad_stop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
      end
      ST_START: begin
        if (half_done) begin
          cnt_clr = 1'b1;
          idx_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          cnt_clr  = 1'b1;
          deliver  = rx_s;
          bad_stop = !rx_s;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Bit-time counter and data bit index; neither wraps, both clear explicitly.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
    end else begin
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);

      if (idx_clr)                                bit_idx_q <= '0;
      else if (shift_en && bit_idx_q != IDX_LAST) bit_idx_q <= bit_idx_q + 3'd1;
    end
  end

  // Data shift register, LSB first: each sample enters at bit 7.
  // NOTE: no reset here; the register is fully rewritten by eight samples
  // before it is ever copied to rxbyte, so its power-up value is never seen.
  always_ff @(posedge hwclk) begin
    if (shift_en) shift_q <= {rx_s, shift_q[7:1]};
  end

  // A delivery over an unacknowledged byte is an overrun; a same-cycle ack
  // means the consumer took the old byte, so nothing was lost.
  assign overrun_event = deliver && rx_valid && !rx_ack;

  // Consumer-facing outputs: byte hold, valid/ack handshake, error flags.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      rxbyte    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (deliver) rxbyte <= shift_q;

      if (deliver)     rx_valid <= 1'b1;
      else if (rx_ack) rx_valid <= 1'b0;

      frame_err <= bad_stop;

      if (overrun_event)           overrun <= 1'b1;
      else if (rx_ack && rx_valid) overrun <= 1'b0;
    end
  end

endmodule
